// File: rtl/matrix_3x3_gen.sv
// matrix_3x3_gen: 3x3 pixel neighbourhood from a raster stream using two line buffers, with top/left zero padding
module matrix_3x3_gen #(
  parameter int IMG_WIDTH = 1280,
  parameter int CNT_W     = 11
) (
  input  logic       video_clk,
  input  logic       rst_n,
  input  logic       pre_vs,
  input  logic       pre_hs,
  input  logic       pre_de,
  input  logic [7:0] pre_data,
  output logic [7:0] matrix11,
  output logic [7:0] matrix12,
  output logic [7:0] matrix13,
  output logic [7:0] matrix21,
  output logic [7:0] matrix22,
  output logic [7:0] matrix23,
  output logic [7:0] matrix31,
  output logic [7:0] matrix32,
  output logic [7:0] matrix33,
  output logic       post_vs,
  output logic       post_hs,
  output logic       post_de
);
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  logic [CNT_W-1:0]      r_col_cnt;
  logic [1:0]            r_row_cnt;
  logic [7:0]            r_lb1 [IMG_WIDTH];
  logic [7:0]            r_lb2 [IMG_WIDTH];
  logic [AW-1:0]         w_addr;
  logic [2:0][7:0]       r_s1;
  logic [2:0][2:0][7:0]  r_m;
  logic [2:0]            r_d1;
  logic [2:0]            r_d2;
  assign w_addr = AW'(r_col_cnt);
  always_ff @(posedge video_clk)
    if (pre_de) begin
      r_lb1[w_addr] <= pre_data;
      r_lb2[w_addr] <= r_lb1[w_addr];
    end
  always_ff @(posedge video_clk or negedge rst_n)
    if (!rst_n) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_d1      <= '0;
      r_d2      <= '0;
    end else begin
      r_col_cnt <= !pre_de ? '0 : (r_col_cnt == CNT_W'(IMG_WIDTH - 1)) ? r_col_cnt : r_col_cnt + 1'b1;
      r_row_cnt <= pre_vs ? 2'd0 : (!pre_de && r_d1[0] && r_row_cnt != 2'd2) ? r_row_cnt + 2'd1 : r_row_cnt;
      r_d1      <= {pre_vs, pre_hs, pre_de};
      r_d2      <= r_d1;
    end
  // rows not yet filled in this frame read stale RAM, so mask them by row count
  always_ff @(posedge video_clk or negedge rst_n)
    if (!rst_n)
      r_s1 <= '0;
    else if (pre_de) begin
      r_s1[2] <= pre_data;
      r_s1[1] <= (r_row_cnt == 2'd0) ? 8'd0 : r_lb1[w_addr];
      r_s1[0] <= (r_row_cnt < 2'd2) ? 8'd0 : r_lb2[w_addr];
    end
  always_ff @(posedge video_clk or negedge rst_n)
    if (!rst_n)
      r_m <= '0;
    else if (!r_d1[0])
      r_m <= '0;
    else
      for (int i = 0; i < 3; i++)
        r_m[i] <= {r_m[i][1], r_m[i][0], r_s1[i]};
  assign matrix11 = r_m[0][2];
  assign matrix12 = r_m[0][1];
  assign matrix13 = r_m[0][0];
  assign matrix21 = r_m[1][2];
  assign matrix22 = r_m[1][1];
  assign matrix23 = r_m[1][0];
  assign matrix31 = r_m[2][2];
  assign matrix32 = r_m[2][1];
  assign matrix33 = r_m[2][0];
  assign {post_vs, post_hs, post_de} = r_d2;
endmodule

// File: doc/matrix_3x3_gen.md
Name: matrix_3x3_gen

Overview:
- Upstream neighbour of the Sobel edge detector in the HDMI picture path.
- Takes a raster-scanned 8-bit grey pixel stream with video timing and keeps the two previous lines in on-chip line buffers.
- Each valid pixel cycle, presents the 3x3 neighbourhood as nine 8-bit taps (matrix11..matrix33) for the downstream convolution stage.
- Forwards the timing signals delayed to match the data, with defined zero padding at the frame and line edges.

Parameters:
- IMG_WIDTH, 1280, active pixels per line; sets line-buffer depth.
- CNT_W, 11, column-counter width; must satisfy 2^CNT_W >= IMG_WIDTH.

Ports:
- video_clk  in  1  pixel clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- pre_vs  in  1  frame sync, active high
- pre_hs  in  1  line sync, passed through only
- pre_de  in  1  data enable; high during active pixels
- pre_data  in  8  grey pixel, valid when pre_de=1
- matrix11, matrix12, matrix13  out  8 each  top row (two lines back), left to right
- matrix21, matrix22, matrix23  out  8 each  middle row (previous line)
- matrix31, matrix32, matrix33  out  8 each  bottom row (current line); matrix33 is the newest pixel
- post_vs, post_hs, post_de  out  1 each  pre_vs, pre_hs, pre_de delayed 2 clk

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All nine matrix outputs, post_* outputs, counters and pipeline registers go to 0.
  - Line-buffer RAM contents are not cleared; they are masked by the row counter.
- col_cnt:
  - Increments every pre_de=1 cycle and clears to 0 when pre_de=0.
  - Saturates at IMG_WIDTH-1, so over-long lines reuse the last address.
- row_cnt (2 bits, saturating at 2):
  - Clears when pre_vs=1.
  - Increments on each pre_de falling edge (pre_de=0 while the previous-cycle pre_de was 1).
- Line buffers lb1 and lb2: depth IMG_WIDTH x 8, one synchronous port each, read-before-write. When pre_de=1 at cycle t:
  - r3 <= pre_data.
  - r2 <= lb1[col_cnt] (old data).
  - r1 <= lb2[col_cnt] (old data).
  - lb1[col_cnt] <= pre_data.
  - lb2[col_cnt] <= old lb1[col_cnt].
- Top padding, applied at stage 1:
  - row_cnt=0: r2 and r1 forced to 0.
  - row_cnt=1: r1 forced to 0.
- Stage 2 (cycle t+2), when de_d1=1: each row shifts left:
  - matrixX1 <= matrixX2, matrixX2 <= matrixX3, matrixX3 <= rX.
- Left-edge padding: when de_d1=0, all nine matrix registers load 0. The first two output pixels of every line therefore carry zero left columns.
- No right or bottom padding is generated; the downstream stage tolerates the edge columns and rows.
- Latency:
  - pre_data to matrix33 is exactly 2 clk.
  - post_vs/post_hs/post_de equal pre_* delayed by 2 registers.
  - The window centre (matrix22) corresponds to the pixel at row-1, col-1 of the newest input.
- Line-to-line gaps (pre_de=0) of any length, including 1 clk, must be supported.
- pre_vs asserted mid-line: row_cnt clears immediately; the data path continues.
- Reset mid-frame: outputs 0 the next edge. The next lines are treated as the top of the frame until row_cnt reaches 2.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset check: hold rst_n=0 while driving random inputs -> all matrix outputs and post_* equal 0. Release rst_n -> they remain 0 until the first pre_de.
- Interior window: IMG_WIDTH=8; frame of 4 lines with pixel = 0x80 + row*16 + col; input at row 2, col 3, then 2 clk later:
  - matrix11/12/13 = 0x81/0x82/0x83
  - matrix21/22/23 = 0x91/0x92/0x93
  - matrix31/32/33 = 0xA1/0xA2/0xA3
- Top padding, same frame:
  - Row 0, col 2 -> rows 1 and 2 of the matrix all 0; matrix31/32/33 = 0x80/0x81/0x82.
  - Row 1, col 2 -> matrix1x = 0; matrix21..23 = 0x80..0x82; matrix31..33 = 0x90..0x92.
- Left padding: row 2, col 0 -> matrix13=0x80, matrix23=0x90, matrix33=0xA0; the other six taps = 0. At col 1: matrix11/21/31 = 0, matrix12 = 0x80.
- Timing alignment: irregular pre_hs/pre_de/pre_vs patterns, including 1-clk line gaps -> post_* are bit-exact copies delayed 2 clk, and the window contents are unaffected by gap length.
- Frame restart with stale RAM: second frame of all 0x55 pixels after pre_vs -> its row 0 window shows matrix1x = matrix2x = 0, not first-frame data.
- Reset mid-frame: assert rst_n=0 mid row 2, then resume -> the next line is treated as row 0 (top rows 0).
